// File: rtl/kex_tile_ctrl.sv
// kex_tile_ctrl: sequencer for the single-port expansion-kernel tile RAM.
// Loads a tile from a valid/ready weight stream, serves random-access reads
// from the expansion PE array, and releases the tile for the next load.
// The controller is the only driver of the RAM address/data/write ports.
// The consumer's release pulse is named tile_release because "release" is a
// reserved SystemVerilog keyword.

module kex_tile_ctrl #(
    parameter int N_ELEM = 512,
    parameter int DATA_W = 11,
    parameter int AW     = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       n_words,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              loaded,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              tile_release,
    output logic              err,
    output logic              busy,
    output logic [AW-1:0]     ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_res
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } state_t;

    localparam logic [AW:0]   NMAX    = (AW+1)'(N_ELEM);
    localparam logic [AW:0]   ONE_LIM = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_CNT = AW'(1);

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   wcnt;
    logic [AW:0]     nlim;
    logic            n_ok;
    logic            rd_in_range;
    logic            handshake;
    logic            last_beat;
    logic            load_new;
    logic            err_next;
    logic            rd_fire;

    assign n_ok        = (n_words != '0) && (n_words <= NMAX);
    assign rd_in_range = ({1'b0, rd_addr} < nlim);
    assign handshake   = ld_valid && (state == LOAD);
    assign last_beat   = handshake && ({1'b0, wcnt} == (nlim - ONE_LIM));

    assign ld_ready = (state == LOAD);
    assign loaded   = (state == FULL);
    assign busy     = (state != IDLE);
    // RAM output is forwarded as-is; it only carries meaning while rd_valid is high.
    assign rd_data  = ram_res;

    // State register; an asynchronous reset abandons any partial tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, RAM port drive and the pulses to be registered for next cycle.
    always_comb begin
        next_state = state;
        ram_addr   = '0;
        ram_data   = '0;
        ram_write  = 1'b0;
        err_next   = 1'b0;
        rd_fire    = 1'b0;
        load_new   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_ok) begin
                        next_state = LOAD;
                        load_new   = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (rd_req) begin
                    err_next = 1'b1;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    ram_write = 1'b1;
                    ram_addr  = wcnt;
                    ram_data  = ld_data;
                    if (last_beat) begin
                        next_state = FULL;
                    end
                end
                if (rd_req) begin
                    err_next = 1'b1;
                end
            end
            FULL: begin
                if (rd_req) begin
                    if (rd_in_range) begin
                        ram_addr = rd_addr;
                        rd_fire  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (start) begin
                    if (n_ok) begin
                        next_state = LOAD;
                        load_new   = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (tile_release) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Tile length capture on an accepted start and write-pointer advance per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
            nlim <= '0;
        end else if (load_new) begin
            nlim <= n_words;
            wcnt <= '0;
        end else if (handshake) begin
            wcnt <= wcnt + ONE_CNT;
        end
    end

    // One-cycle delayed pulses: read data valid and illegal-request error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            err      <= err_next;
        end
    end

endmodule

// File: doc/kex_tile_ctrl.md
Name: kex_tile_ctrl

Overview:
- Sequencer for the single-port expansion-kernel tile RAM (1x1 expansion convolution weights, KEX_N_ELEM words of WG_W+clog2(Npar) bits, 1-cycle read latency, write-through on write).
- Fills the RAM from a valid/ready weight stream (DMA side), then serves random-access reads from the expansion PE array, then releases the tile for the next load.
- Owns every RAM port; no other block drives the RAM.

Parameters:
- N_ELEM, 512, tile depth in words (set to KEX_N_ELEM).
- DATA_W, 11, word width (set to WG_W + $clog2(Npar)).
- AW, $clog2(N_ELEM), RAM address width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a tile load of n_words words.
- n_words  in  AW+1  words to load, sampled on start; legal range 1..N_ELEM.
- ld_data  in  DATA_W  weight word from the stream.
- ld_valid  in  1  ld_data is valid.
- ld_ready  out  1  controller accepts a word this cycle.
- loaded  out  1  tile complete and readable.
- rd_req  in  1  read request from the PE array.
- rd_addr  in  AW  word address for rd_req.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  DATA_W  read word.
- release  in  1  one-cycle pulse; consumer is finished with the tile.
- err  out  1  one-cycle pulse on an illegal request.
- busy  out  1  state is not IDLE.
- ram_addr  out  AW  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_write  out  1  RAM write enable.
- ram_res  in  DATA_W  RAM read data.

Behaviour:
- Reset (rst=0, async): state IDLE; wcnt=0, nlim=0. ld_ready, loaded, rd_valid, err, busy, ram_write all 0; ram_addr=0, ram_data=0. RAM contents are not cleared and are treated as invalid.
- FSM states: IDLE, LOAD, FULL. ld_ready = (state==LOAD); loaded = (state==FULL); busy = (state!=IDLE).
- IDLE:
  - start with 1<=n_words<=N_ELEM: nlim<=n_words, wcnt<=0, next LOAD.
  - start with n_words=0 or n_words>N_ELEM: err pulses next cycle; stay IDLE.
  - rd_req: err pulses next cycle; no rd_valid.
  - release: ignored.
- LOAD:
  - On handshake (ld_valid & ld_ready), combinationally: ram_write=1, ram_addr=wcnt, ram_data=ld_data; wcnt<=wcnt+1.
  - With no handshake: ram_write=0.
  - Handshake with wcnt==nlim-1: next FULL. ld_ready drops in the cycle after the last beat.
  - Sustains 1 word/cycle.
  - rd_req: err pulse, no read. start and release: ignored.
- FULL:
  - rd_req with rd_addr<nlim: ram_addr=rd_addr, ram_write=0 that cycle. rd_valid=1 exactly one cycle later, with rd_data=ram_res. Back-to-back reads give 1 word/cycle.
  - rd_req with rd_addr>=nlim: RAM is not addressed for the consumer, no rd_valid, err pulses next cycle.
  - release: next IDLE. A legal rd_req in the same cycle is still served (rd_valid the next cycle, in IDLE).
  - start (legal n_words): next LOAD with new nlim, wcnt=0 (implicit release). A same-cycle legal rd_req is still served. A write cannot occur that cycle because state is not LOAD yet.
  - start (illegal n_words): err pulse, stay FULL.
- rd_data is combinational from ram_res and meaningful only when rd_valid=1. rd_valid is never asserted in the cycle after a write, so the RAM's write-through echo is never presented as read data.
- Idle RAM drive (no write, no read): ram_addr=0, ram_data=0, ram_write=0.
- Reset mid-LOAD or mid-FULL: immediate return to IDLE; a pending rd_valid is cancelled; the partial tile is discarded.

Test Plan:
- Basic load: rst release, start n_words=4, ld_valid held high with 0x011, 0x022, 0x033, 0x044 -> ram_write=1 for 4 cycles at addr 0..3 with matching data; loaded=1 and ld_ready=0 from the cycle after the 4th beat.
- Backpressure: same load with ld_valid toggled 1,0,0,1,1,0,1 -> exactly 4 writes, addresses contiguous 0..3 with no skips; FULL after the 4th handshake only.
- Reads: in FULL, rd_req on 3 consecutive cycles at addr 3, 0, 2 -> rd_valid high 3 consecutive cycles, each one cycle after its request, data 0x044, 0x011, 0x033.
- Illegal requests:
  - rd_addr=4 with nlim=4 -> err pulse, no rd_valid.
  - start n_words=0, then n_words=513 in IDLE -> err pulse each time, busy stays 0.
  - rd_req during LOAD -> err pulse, load unaffected.
- Reset mid-load: rst=0 after 2 of 4 beats -> all outputs 0 immediately, state IDLE. A new start n_words=2 writes addr 0, 1 and reaches FULL.
- Release/reload:
  - release plus rd_req addr 1 in the same cycle -> rd_valid next cycle with data 0x022, then loaded=0, busy=0.
  - start n_words=8 while FULL -> LOAD with wcnt restarting at addr 0.
